// File: rtl/regfile_wb_sink.sv
// Architectural register file x0..x31 with write-through bypass on both read ports,
// an unbypassed debug read port and a committed-write counter.
module regfile_wb_sink #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RFWe,
   input  logic [ADDR_W-1:0] rfwaddr,
   input  logic [DATA_W-1:0] rfwdata,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int unsigned NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              commit;

   // Writes to x0 are dropped here, so regs_q[0] stays at its reset value.
   assign commit = RFWe && (rfwaddr != '0);
   assign cnt_d  = cnt_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         cnt_q <= '0;
      end else if (commit) begin
         regs_q[rfwaddr] <= rfwdata;
         cnt_q           <= cnt_d;
      end
   end

   // Reads are forced to zero while reset is held, bypass included.
   always_comb begin
      rd1 = '0;
      if (!reset && (ra1 != '0)) begin
         if (RFWe && (rfwaddr == ra1)) rd1 = rfwdata;
         else                          rd1 = regs_q[ra1];
      end
   end

   always_comb begin
      rd2 = '0;
      if (!reset && (ra2 != '0)) begin
         if (RFWe && (rfwaddr == ra2)) rd2 = rfwdata;
         else                          rd2 = regs_q[ra2];
      end
   end

   always_comb begin
      dbg_data = '0;
      if (!reset && (dbg_addr != '0)) begin
         dbg_data = regs_q[dbg_addr];
      end
   end

   assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Randomized self-checking bench for regfile_wb_sink against a behavioural model;
// a second instance with a 4-bit counter exercises counter wrap.
module tb_regfile_wb_sink;

   logic        clk = 1'b0;
   logic        reset;
   logic        RFWe;
   logic [4:0]  rfwaddr;
   logic [31:0] rfwdata;
   logic [4:0]  ra1, ra2, dbg_addr;
   logic [31:0] rd1, rd2, dbg_data, wr_count;
   logic [31:0] rd1_b, rd2_b, dbg_b;
   logic [3:0]  wr4;

   int total = 0;
   int bad   = 0;

   logic [31:0] mregs [32];
   int unsigned mcnt;

   regfile_wb_sink #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .RFWe(RFWe), .rfwaddr(rfwaddr), .rfwdata(rfwdata),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
   );

   regfile_wb_sink #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .RFWe(RFWe), .rfwaddr(rfwaddr), .rfwdata(rfwdata),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_count(wr4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (reset || a == 5'd0) return 32'd0;
      if (RFWe && rfwaddr == a) return rfwdata;
      return mregs[a];
   endfunction

   function automatic logic [31:0] exp_dbg(input logic [4:0] a);
      if (reset || a == 5'd0) return 32'd0;
      return mregs[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 0;
   endtask

   // Advance one clock edge, applying the architectural write rule to the model.
   task automatic tick();
      @(posedge clk);
      if (!reset && RFWe && rfwaddr != 5'd0) begin
         mregs[rfwaddr] = rfwdata;
         mcnt++;
      end
      #1;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      RFWe = 1'b1; rfwaddr = a; rfwdata = d;
      tick();
      RFWe = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; RFWe = 1'b1; rfwaddr = 5'd5; rfwdata = 32'hCAFE_F00D;
      ra1 = 5'd5; ra2 = 5'd9; dbg_addr = 5'd5;
      model_clear();
      tick();
      #1;
      total++; if (rd1 !== 32'd0) begin bad++; $display("FAIL reset_rd1_bypass got=%h exp=%h", rd1, 32'd0); end
      total++; if (rd2 !== 32'd0) begin bad++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'd0); end
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", wr_count); end
      #1 reset = 1'b0; RFWe = 1'b0;
      tick();
      write(5'd5, 32'hDEAD_BEEF);
      total++; if (dbg_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pre_reset_x5 got=%h exp=%h", dbg_data, 32'hDEAD_BEEF); end
      // asynchronous assertion in the middle of a write cycle
      RFWe = 1'b1; rfwaddr = 5'd5; rfwdata = 32'h0000_0123;
      #2 reset = 1'b1;
      model_clear();
      #1;
      total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL async_reset_dbg got=%h exp=0", dbg_data); end
      total++; if (rd1 !== 32'd0) begin bad++; $display("FAIL async_reset_rd1 got=%h exp=0", rd1); end
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL async_reset_cnt got=%0d exp=0", wr_count); end
      tick();
      #2 reset = 1'b0; RFWe = 1'b0;
      #1;
      total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL discarded_write got=%h exp=0", dbg_data); end
      tick();
   endtask

   task automatic test_basic();
      write(5'd1, 32'h1234_5678);
      write(5'd31, 32'hFFFF_FFFF);
      ra1 = 5'd1; ra2 = 5'd31; #1;
      total++; if (rd1 !== 32'h1234_5678) begin bad++; $display("FAIL basic_rd1 got=%h exp=%h", rd1, 32'h1234_5678); end
      total++; if (rd2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL basic_rd2 got=%h exp=%h", rd2, 32'hFFFF_FFFF); end
      total++; if (wr_count !== 32'd2) begin bad++; $display("FAIL basic_cnt got=%0d exp=2", wr_count); end
   endtask

   task automatic test_x0();
      int unsigned c0;
      c0 = mcnt;
      RFWe = 1'b1; rfwaddr = 5'd0; rfwdata = 32'hA5A5_A5A5; ra1 = 5'd0; dbg_addr = 5'd0; #1;
      total++; if (rd1 !== 32'd0) begin bad++; $display("FAIL x0_bypass got=%h exp=0", rd1); end
      tick();
      RFWe = 1'b0; #1;
      total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL x0_dbg got=%h exp=0", dbg_data); end
      total++; if (wr_count !== c0) begin bad++; $display("FAIL x0_cnt got=%0d exp=%0d", wr_count, c0); end
   endtask

   task automatic test_bypass();
      write(5'd7, 32'h11);
      RFWe = 1'b1; rfwaddr = 5'd7; rfwdata = 32'h22; ra1 = 5'd7; ra2 = 5'd7; dbg_addr = 5'd7; #1;
      total++; if (rd1 !== 32'h22) begin bad++; $display("FAIL bypass_rd1 got=%h exp=22", rd1); end
      total++; if (rd2 !== 32'h22) begin bad++; $display("FAIL bypass_rd2 got=%h exp=22", rd2); end
      total++; if (dbg_data !== 32'h11) begin bad++; $display("FAIL bypass_dbg_old got=%h exp=11", dbg_data); end
      tick();
      RFWe = 1'b0; #1;
      total++; if (dbg_data !== 32'h22) begin bad++; $display("FAIL bypass_dbg_new got=%h exp=22", dbg_data); end
   endtask

   task automatic test_we_low();
      int unsigned c0;
      write(5'd3, 32'h0000_0A0A);
      c0 = mcnt;
      RFWe = 1'b0; rfwaddr = 5'd3; rfwdata = 32'h55; ra1 = 5'd3; dbg_addr = 5'd3; #1;
      total++; if (rd1 !== 32'h0000_0A0A) begin bad++; $display("FAIL we_low_rd1 got=%h exp=%h", rd1, 32'h0000_0A0A); end
      tick();
      total++; if (dbg_data !== 32'h0000_0A0A) begin bad++; $display("FAIL we_low_dbg got=%h exp=%h", dbg_data, 32'h0000_0A0A); end
      total++; if (wr_count !== c0) begin bad++; $display("FAIL we_low_cnt got=%0d exp=%0d", wr_count, c0); end
   endtask

   task automatic test_random();
      logic [31:0] e1, e2, ed;
      for (int n = 0; n < 300; n++) begin
         RFWe    = ($urandom_range(0, 3) != 0);
         rfwaddr = 5'($urandom_range(0, 31));
         rfwdata = $urandom;
         ra1      = ($urandom_range(0, 3) == 0) ? rfwaddr : 5'($urandom_range(0, 31));
         ra2      = ($urandom_range(0, 3) == 0) ? rfwaddr : 5'($urandom_range(0, 31));
         dbg_addr = ($urandom_range(0, 3) == 0) ? rfwaddr : 5'($urandom_range(0, 31));
         #1;
         e1 = exp_rd(ra1); e2 = exp_rd(ra2); ed = exp_dbg(dbg_addr);
         total++; if (rd1 !== e1) begin bad++; $display("FAIL rand_rd1 n=%0d ra=%0d got=%h exp=%h", n, ra1, rd1, e1); end
         total++; if (rd2 !== e2) begin bad++; $display("FAIL rand_rd2 n=%0d ra=%0d got=%h exp=%h", n, ra2, rd2, e2); end
         total++; if (dbg_data !== ed) begin bad++; $display("FAIL rand_dbg n=%0d a=%0d got=%h exp=%h", n, dbg_addr, dbg_data, ed); end
         total++; if (wr_count !== mcnt) begin bad++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, wr_count, mcnt); end
         total++; if (wr4 !== 4'(mcnt % 16)) begin bad++; $display("FAIL rand_cnt4 n=%0d got=%0d exp=%0d", n, wr4, mcnt % 16); end
         tick();
      end
      RFWe = 1'b0;
   endtask

   task automatic test_wrap();
      #2 reset = 1'b1;
      model_clear();
      #2 reset = 1'b0;
      tick();
      for (int n = 0; n < 16; n++) write(5'($urandom_range(1, 31)), $urandom);
      total++; if (wr4 !== 4'd0) begin bad++; $display("FAIL wrap16_cnt4 got=%0d exp=0", wr4); end
      total++; if (wr_count !== 32'd16) begin bad++; $display("FAIL wrap16_cnt got=%0d exp=16", wr_count); end
      write(5'($urandom_range(1, 31)), $urandom);
      total++; if (wr4 !== 4'd1) begin bad++; $display("FAIL wrap17_cnt4 got=%0d exp=1", wr4); end
      total++; if (wr_count !== 32'd17) begin bad++; $display("FAIL wrap17_cnt got=%0d exp=17", wr_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_x0();
      test_bypass();
      test_we_low();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
